if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

Instruction-fetch stage of the 5-stage pipeline. It owns the fetch PC, issues one outstanding request at a time to instruction memory, and presents {instruction, PC, PC+4, valid} to the IF/ID pipeline register, which captures these values every clock. It absorbs ID-stage stalls with a one-entry hold buffer. It handles branch/jump redirects, including squashing an in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP_INSTR, 32'h0000_0000, instruction word driven on bubbles
- clk  in  1  pipeline clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- id_stall  in  1  ID cannot accept; the IF/ID register must recapture identical values
- redirect_valid  in  1  one-cycle pulse from branch/jump resolution
- redirect_pc  in  32  new fetch target; bits [1:0] ignored and forced to 0
- imem_req  out  1  fetch request; once raised, held until completion
- imem_addr  out  32  word-aligned fetch address; stable while a request is pending
- imem_rvalid  in  1  completion; may be high in the same cycle imem_req rises (zero-wait SRAM)
- imem_rdata  in  32  instruction word, valid when imem_req && imem_rvalid
- if_instrn  out  32  instruction to IF/ID
- if_pc_addrout  out  32  address of if_instrn
- if_pcp4  out  32  if_pc_addrout + 4
- if_valid  out  1  1 = real instruction, 0 = bubble

## Operation
- Internal state:
  - fetch_pc: next address to issue.
  - pending: a request is open and not yet completed.
  - req_addr: address of the open request.
  - hold buffer: {instr, pc}.
  - FSM states: RUN, HOLD, DRAIN.
- Completion: any cycle with imem_req && imem_rvalid.
- imem_req = pending | (RUN && !id_stall) | DRAIN. It is forced to 0 while rst_n is low.
- imem_addr = pending ? req_addr : fetch_pc.
- A request that is issued and does not complete in the same cycle sets pending and latches req_addr <= fetch_pc.
- RUN:
  - Completion && !id_stall: outputs <= {rdata, addr, addr+4, 1}; fetch_pc += 4.
  - Completion && id_stall (only possible with pending): hold buffer <= {rdata, addr}; fetch_pc += 4; -> HOLD.
  - No completion && !id_stall: outputs <= bubble {NOP_INSTR, valid=0}. PC outputs retain their previous values.
  - id_stall && no completion: all outputs hold.
- HOLD:
  - imem_req = 0.
  - While id_stall: outputs hold.
  - When !id_stall: outputs <= {buf_instr, buf_pc, buf_pc+4, 1}; -> RUN.
- DRAIN:
  - Waits out the squashed request. imem_req = 1; imem_addr = req_addr.
  - Outputs are bubbles.
  - On completion the data is discarded, pending clears, -> RUN. Issue from fetch_pc starts the next cycle.
- Redirect (highest priority, any state, overrides id_stall):
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - Outputs <= bubble; hold buffer invalidated.
  - If a request is pending or issued and not completing this cycle -> DRAIN; otherwise -> RUN.
  - Data completing in the redirect cycle is discarded.
  - Redirect while in DRAIN: update fetch_pc, remain in DRAIN.
- Arithmetic: all PC math is 32-bit modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset (async, rst_n low):
  - State: RUN; fetch_pc = RESET_PC; pending = 0; hold buffer invalid.
  - Outputs: if_instrn = NOP_INSTR; if_pc_addrout = 0; if_pcp4 = 0; if_valid = 0; imem_req = 0.
- First request: imem_req rises in the first cycle after rst_n deasserts, at address RESET_PC.
- Throughput and latency:
  - Zero-wait memory, no stall: one instruction per clock.
  - Latency: request cycle -> registered outputs valid the next cycle.
- N-wait memory: a bubble on each wait cycle.
- Stall release from HOLD: buffered instruction appears on the next edge. Fetch resumes one cycle later (one-cycle penalty).
- Redirect: target is requested in the cycle after the redirect when nothing is pending. Otherwise it is requested in the cycle after the squashed completion.
- Reset mid-request: pending is dropped; memory must tolerate the request being abandoned.

## Test plan
- Reset with RESET_PC=32'h100 and zero-wait memory returning addr-derived data -> imem_addr sequence 0x100, 0x104, 0x108 on consecutive cycles; if_valid=1 from the second cycle; if_pcp4 = if_pc_addrout + 4.
- Memory with 2 wait states -> imem_addr held stable until rvalid; if_valid pattern 0,0,1 repeating; imem_req never drops mid-request.
- Assert id_stall for 3 cycles while a request completes -> outputs frozen; instruction at the stalled address appears once after release; no address skipped or duplicated.
- redirect_valid with redirect_pc=32'h2003 while a 3-cycle request to 0x10C is pending -> DRAIN; old data never appears with if_valid=1; next imem_addr = 0x2000.
- Redirect in the same cycle as completion and id_stall=1 -> completion discarded, bubble output, next fetch at target.
- fetch_pc = 32'hFFFF_FFFC -> if_pcp4 = 0, next imem_addr = 0; assert rst_n low mid-stream -> all outputs and imem_req return to reset values immediately.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, keeps one imem request in flight,
// absorbs ID stalls with a one-entry hold buffer and squashes fetches on redirect.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_instrn,
  output logic [31:0] if_pc_addrout,
  output logic [31:0] if_pcp4,
  output logic        if_valid
);
  typedef enum logic [1:0] {RUN, HOLD, DRAIN} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        valid;
  } ifid_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic        pending_q, pending_d;
  ifid_t       out_q, out_d;
  logic        complete;

  // The RUN term is combinational from the state regs, so gate it while in reset.
  assign imem_req  = rst_n & (pending_q | ((state_q == RUN) & ~id_stall) | (state_q == DRAIN));
  assign imem_addr = pending_q ? req_addr_q : fetch_pc_q;
  assign complete  = imem_req & imem_rvalid;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    pending_d   = pending_q;
    out_d       = out_q;

    if (redirect_valid) begin
      fetch_pc_d  = {redirect_pc[31:2], 2'b00};
      out_d.instr = NOP_INSTR;
      out_d.valid = 1'b0;
      // A request that cannot be cancelled must be waited out before the target is issued.
      if (imem_req && !complete) begin
        state_d    = DRAIN;
        pending_d  = 1'b1;
        req_addr_d = imem_addr;
      end else begin
        state_d   = RUN;
        pending_d = 1'b0;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (complete) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            pending_d  = 1'b0;
            if (id_stall) begin
              buf_instr_d = imem_rdata;
              buf_pc_d    = imem_addr;
              state_d     = HOLD;
            end else begin
              out_d = '{instr: imem_rdata, pc: imem_addr, pcp4: imem_addr + 32'd4, valid: 1'b1};
            end
          end else begin
            if (imem_req) begin
              pending_d  = 1'b1;
              req_addr_d = imem_addr;
            end
            if (!id_stall) begin
              out_d.instr = NOP_INSTR;
              out_d.valid = 1'b0;
            end
          end
        end
        HOLD: begin
          if (!id_stall) begin
            out_d   = '{instr: buf_instr_q, pc: buf_pc_q, pcp4: buf_pc_q + 32'd4, valid: 1'b1};
            state_d = RUN;
          end
        end
        DRAIN: begin
          out_d.instr = NOP_INSTR;
          out_d.valid = 1'b0;
          if (complete) begin
            pending_d = 1'b0;
            state_d   = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= 32'h0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= 32'h0;
      pending_q   <= 1'b0;
      out_q       <= '{instr: NOP_INSTR, pc: 32'h0, pcp4: 32'h0, valid: 1'b0};
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      pending_q   <= pending_d;
      out_q       <= out_d;
    end
  end

  assign if_instrn     = out_q.instr;
  assign if_pc_addrout = out_q.pc;
  assign if_pcp4       = out_q.pcp4;
  assign if_valid      = out_q.valid;
endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: random-latency memory, program-order scoreboard
// plus directed scenarios for reset, wait states, stalls, redirects and wrap.
module tb_if_fetch_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req, imem_rvalid, if_valid;
  logic [31:0] imem_addr, imem_rdata, if_instrn, if_pc_addrout, if_pcp4;

  int n_pass = 0;
  int n_chk  = 0;

  if_fetch_stage #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .id_stall(id_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_instrn(if_instrn), .if_pc_addrout(if_pc_addrout),
    .if_pcp4(if_pcp4), .if_valid(if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory: completes after wtarget wait cycles (0 = same cycle as the request).
  int wmin = 0, wmax = 0, wcnt, wtarget;
  assign imem_rvalid = imem_req && (wcnt >= wtarget);
  assign imem_rdata  = mem(imem_addr);
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0; wtarget <= wmin;
    end else if (imem_req && imem_rvalid) begin
      wcnt <= 0; wtarget <= int'($urandom_range(wmax, wmin));
    end else if (imem_req) begin
      wcnt <= wcnt + 1;
    end
  end

  // Scoreboard state: next expected program-order PC and request-protocol tracking.
  logic [31:0] exp_pc;
  logic        open_q = 1'b0;
  logic [31:0] open_addr;
  logic        cap_req, cap_rvalid;
  logic [31:0] cap_addr;

  task automatic step(input logic stall, input logic redir, input logic [31:0] rpc);
    logic [31:0] p_instr, p_pc, p_pcp4;
    logic        p_valid;
    id_stall = stall; redirect_valid = redir; redirect_pc = rpc;
    @(negedge clk);
    cap_req = imem_req; cap_addr = imem_addr; cap_rvalid = imem_rvalid;
    if (open_q) begin
      n_chk++;
      if (!imem_req || imem_addr !== open_addr)
        $display("FAIL req_held got req=%0b addr=%h exp req=1 addr=%h", imem_req, imem_addr, open_addr);
      else n_pass++;
    end
    open_q = imem_req && !imem_rvalid; open_addr = imem_addr;
    p_instr = if_instrn; p_pc = if_pc_addrout; p_pcp4 = if_pcp4; p_valid = if_valid;
    @(posedge clk); #1;
    n_chk++;
    if (redir) begin
      if (if_valid !== 1'b0 || if_instrn !== NOP)
        $display("FAIL redirect_bubble got v=%0b i=%h exp v=0 i=%h", if_valid, if_instrn, NOP);
      else n_pass++;
      exp_pc = {rpc[31:2], 2'b00};
    end else if (stall) begin
      if ({if_instrn, if_pc_addrout, if_pcp4, if_valid} !== {p_instr, p_pc, p_pcp4, p_valid})
        $display("FAIL stall_hold got %h/%h/%h/%0b exp %h/%h/%h/%0b", if_instrn, if_pc_addrout,
                 if_pcp4, if_valid, p_instr, p_pc, p_pcp4, p_valid);
      else n_pass++;
    end else if (if_valid === 1'b1) begin
      if (if_pc_addrout !== exp_pc || if_instrn !== mem(exp_pc) || if_pcp4 !== exp_pc + 32'd4)
        $display("FAIL instr_order got pc=%h i=%h p4=%h exp pc=%h i=%h p4=%h", if_pc_addrout,
                 if_instrn, if_pcp4, exp_pc, mem(exp_pc), exp_pc + 32'd4);
      else n_pass++;
      exp_pc = exp_pc + 32'd4;
    end else begin
      if (if_valid !== 1'b0 || if_instrn !== NOP || if_pc_addrout !== p_pc || if_pcp4 !== p_pcp4)
        $display("FAIL bubble got v=%0b i=%h pc=%h p4=%h exp v=0 i=%h pc=%h p4=%h", if_valid,
                 if_instrn, if_pc_addrout, if_pcp4, NOP, p_pc, p_pcp4);
      else n_pass++;
    end
  endtask

  task automatic apply_reset(input int wlo, input int whi);
    wmin = wlo; wmax = whi;
    rst_n = 1'b0; id_stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    @(posedge clk); #1; @(posedge clk); #1;
    rst_n = 1'b1; open_q = 1'b0; exp_pc = RST_PC;
  endtask

  task automatic check_reset_outputs(input string tag);
    n_chk++;
    if (imem_req !== 1'b0 || if_valid !== 1'b0 || if_instrn !== NOP ||
        if_pc_addrout !== 32'h0 || if_pcp4 !== 32'h0)
      $display("FAIL %s got req=%0b v=%0b i=%h pc=%h p4=%h exp all zero/NOP", tag, imem_req,
               if_valid, if_instrn, if_pc_addrout, if_pcp4);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; id_stall = 1'b0;
    #2;
    check_reset_outputs("reset_state");
  endtask

  task automatic test_zero_wait();
    apply_reset(0, 0);
    step(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (cap_req !== 1'b1 || cap_addr !== 32'h100)
      $display("FAIL first_req got req=%0b addr=%h exp req=1 addr=00000100", cap_req, cap_addr);
    else n_pass++;
    n_chk++;
    if (if_valid !== 1'b1) $display("FAIL first_valid got %0b exp 1", if_valid); else n_pass++;
    step(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (cap_addr !== 32'h104) $display("FAIL seq_addr1 got %h exp 00000104", cap_addr); else n_pass++;
    step(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (cap_addr !== 32'h108) $display("FAIL seq_addr2 got %h exp 00000108", cap_addr); else n_pass++;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_wait2();
    apply_reset(2, 2);
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 1'b0, 32'h0);
      n_chk++;
      if (if_valid !== (i % 3 == 2) || cap_req !== 1'b1)
        $display("FAIL wait2_pattern cyc=%0d got v=%0b req=%0b exp v=%0b req=1", i, if_valid,
                 cap_req, (i % 3 == 2));
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    apply_reset(1, 1);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    n_chk++;
    if (cap_rvalid !== 1'b1) $display("FAIL stall_complete got rvalid=%0b exp 1", cap_rvalid); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b0, 32'h0);
      n_chk++;
      if (cap_req !== 1'b0) $display("FAIL hold_noreq got req=%0b exp 0", cap_req); else n_pass++;
    end
    step(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (if_valid !== 1'b1 || if_pc_addrout !== 32'h100 || cap_req !== 1'b0)
      $display("FAIL hold_release got v=%0b pc=%h req=%0b exp v=1 pc=00000100 req=0", if_valid,
               if_pc_addrout, cap_req);
    else n_pass++;
    step(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (cap_req !== 1'b1 || cap_addr !== 32'h104)
      $display("FAIL resume_fetch got req=%0b addr=%h exp req=1 addr=00000104", cap_req, cap_addr);
    else n_pass++;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_redirect_drain();
    bit found = 0;
    apply_reset(2, 2);
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b0, 1'b0, 32'h0);
      if (cap_req && cap_addr == 32'h10C) found = 1;
    end
    n_chk++;
    if (!found) $display("FAIL drain_reach got no request to 0000010c exp one within 40 cycles");
    else n_pass++;
    step(1'b0, 1'b1, 32'h2003);
    n_chk++;
    if (cap_rvalid !== 1'b0 || cap_addr !== 32'h10C)
      $display("FAIL drain_pending got rvalid=%0b addr=%h exp rvalid=0 addr=0000010c", cap_rvalid, cap_addr);
    else n_pass++;
    step(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (cap_req !== 1'b1 || cap_addr !== 32'h10C || cap_rvalid !== 1'b1)
      $display("FAIL drain_wait got req=%0b addr=%h rv=%0b exp 1/0000010c/1", cap_req, cap_addr, cap_rvalid);
    else n_pass++;
    step(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (cap_req !== 1'b1 || cap_addr !== 32'h2000)
      $display("FAIL drain_target got req=%0b addr=%h exp req=1 addr=00002000", cap_req, cap_addr);
    else n_pass++;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_redirect_complete_stall();
    apply_reset(1, 1);
    step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h3000);
    n_chk++;
    if (cap_rvalid !== 1'b1) $display("FAIL redir_cmpl got rvalid=%0b exp 1", cap_rvalid); else n_pass++;
    step(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (cap_req !== 1'b1 || cap_addr !== 32'h3000)
      $display("FAIL redir_target got req=%0b addr=%h exp req=1 addr=00003000", cap_req, cap_addr);
    else n_pass++;
    step(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (if_valid !== 1'b1 || if_pc_addrout !== 32'h3000)
      $display("FAIL redir_first got v=%0b pc=%h exp v=1 pc=00003000", if_valid, if_pc_addrout);
    else n_pass++;
  endtask

  task automatic test_wrap();
    apply_reset(0, 0);
    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'hFFFF_FFFF);
    step(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (cap_addr !== 32'hFFFF_FFFC || if_pc_addrout !== 32'hFFFF_FFFC || if_pcp4 !== 32'h0)
      $display("FAIL wrap_top got addr=%h pc=%h p4=%h exp fffffffc/fffffffc/00000000", cap_addr,
               if_pc_addrout, if_pcp4);
    else n_pass++;
    step(1'b0, 1'b0, 32'h0);
    n_chk++;
    if (cap_addr !== 32'h0 || if_pc_addrout !== 32'h0 || if_valid !== 1'b1)
      $display("FAIL wrap_zero got addr=%h pc=%h v=%0b exp 00000000/00000000/1", cap_addr,
               if_pc_addrout, if_valid);
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset(0, 3);
    for (int i = 0; i < 600; i++)
      step(($urandom % 10) < 3, ($urandom % 25) == 0, $urandom);
  endtask

  task automatic test_reset_mid();
    apply_reset(2, 3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    apply_reset(0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait2();
    test_stall();
    test_redirect_drain();
    test_redirect_complete_stall();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
